// File: rtl/kv_flow_table_if.sv
// Request/reply bundle between the packet parser and the flow table.
// Ports: in_key/in_flag/in_valid (parser -> table), out_valid/out_flag (table -> parser).
interface kv_flow_table_if #(
    parameter int KEY_SIZE = 96
);
    logic [KEY_SIZE-1:0] in_key;
    logic [3:0]          in_flag;
    logic                in_valid;
    logic                out_valid;
    logic [3:0]          out_flag;

    modport master (
        output in_key, in_flag, in_valid,
        input  out_valid, out_flag
    );

    modport slave (
        input  in_key, in_flag, in_valid,
        output out_valid, out_flag
    );
endinterface

// File: rtl/kv_flow_table.sv
// Direct-mapped flow table: DNS suspects, ICMP arrests, blocks repeat offenders.
// Ports: clk156, eth_rst (sync, active-high), bus (slave side), init_done, debug.
module kv_flow_table #(
    parameter int KEY_SIZE = 96,
    parameter int IDX_BITS = 10
) (
    input  logic           clk156,
    input  logic           eth_rst,
    kv_flow_table_if.slave bus,
    output logic           init_done,
    output logic [7:0]     debug
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [1:0] ST_SUSPECT = 2'b01;
    localparam logic [1:0] ST_ARREST  = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [1:0]          status;
        logic [KEY_SIZE-1:0] tag;
    } entry_t;

    typedef enum logic {S_INIT, S_RUN} state_t;

    // Bit i of the key lands in bit (i mod IDX_BITS): same as XOR of
    // zero-padded IDX_BITS-wide chunks.
    function automatic logic [IDX_BITS-1:0] fold_idx(
        input logic [KEY_SIZE-1:0] key
    );
        logic [IDX_BITS-1:0] f;
        f = '0;
        for (int i = 0; i < KEY_SIZE; i++) begin
            f[i % IDX_BITS] ^= key[i];
        end
        return f;
    endfunction

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] init_cnt_q, init_cnt_d;

    entry_t              mem [DEPTH];
    entry_t              rd_q;
    logic                mem_we;
    logic [IDX_BITS-1:0] mem_widx;
    entry_t              mem_wdata;

    logic                s1_valid_q;
    logic                s1_run_q;
    logic [1:0]          s1_op_q;
    logic [KEY_SIZE-1:0] s1_key_q;
    logic [IDX_BITS-1:0] s1_idx_q;

    logic                byp_valid_q;
    logic [IDX_BITS-1:0] byp_idx_q;
    entry_t              byp_data_q;

    logic                out_valid_q;
    logic [3:0]          out_flag_q;
    logic [6:0]          blk_q;

    entry_t              ent;
    logic                hit;
    logic                wr_en;
    entry_t              wr_data;
    logic [3:0]          flag_d;
    logic                blk_inc;

    logic                unused_flag_bits;
    assign unused_flag_bits = ^{bus.in_flag[3], bus.in_flag[0]};

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (&init_cnt_q) state_d = S_RUN;
            end
            default: ;
        endcase
    end

    // The previous request's write lands on the same edge this request's
    // RAM read was launched, so the RAM returned stale data: forward it.
    always_comb begin
        if (byp_valid_q && (byp_idx_q == s1_idx_q)) begin
            ent = byp_data_q;
        end else begin
            ent = rd_q;
        end
    end

    assign hit = ent.valid && (ent.tag == s1_key_q);

    always_comb begin
        wr_en   = 1'b0;
        wr_data = ent;
        flag_d  = 4'b0000;
        blk_inc = 1'b0;
        if (s1_valid_q && s1_run_q) begin
            case (s1_op_q)
                ST_SUSPECT: begin
                    if (hit && ent.status == ST_ARREST) begin
                        flag_d  = {1'b0, ST_ARREST, 1'b1};
                        blk_inc = 1'b1;
                    end else if (hit) begin
                        flag_d = {1'b0, ST_SUSPECT, 1'b1};
                    end else begin
                        wr_en          = 1'b1;
                        wr_data.valid  = 1'b1;
                        wr_data.status = ST_SUSPECT;
                        wr_data.tag    = s1_key_q;
                        flag_d         = {1'b0, ST_SUSPECT, 1'b0};
                    end
                end
                ST_ARREST: begin
                    if (hit) begin
                        wr_en          = 1'b1;
                        wr_data.status = ST_ARREST;
                        flag_d         = 4'b0111;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = s1_idx_q;
        mem_wdata = wr_data;
        if (!eth_rst) begin
            if (state_q == S_INIT) begin
                mem_we    = 1'b1;
                mem_widx  = init_cnt_q;
                mem_wdata = '0;
            end else begin
                mem_we = wr_en;
            end
        end
    end

    always_ff @(posedge clk156) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
        rd_q <= mem[fold_idx(bus.in_key)];
    end

    always_ff @(posedge clk156) begin
        s1_op_q    <= bus.in_flag[2:1];
        s1_key_q   <= bus.in_key;
        s1_idx_q   <= fold_idx(bus.in_key);
        byp_idx_q  <= s1_idx_q;
        byp_data_q <= wr_data;
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            s1_valid_q  <= 1'b0;
            s1_run_q    <= 1'b0;
            byp_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_flag_q  <= 4'b0000;
            blk_q       <= '0;
        end else begin
            s1_valid_q  <= bus.in_valid;
            s1_run_q    <= (state_q == S_RUN);
            byp_valid_q <= wr_en;
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) out_flag_q <= flag_d;
            if (blk_inc && (blk_q != 7'h7F)) blk_q <= blk_q + 7'd1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_flag  = out_flag_q;
    assign init_done     = (state_q == S_RUN);
    assign debug         = {init_done, blk_q};

endmodule

// File: tb/tb_kv_flow_table.sv
// Bench for kv_flow_table: directed requests, table-level model, per-cycle compare.
// Ports: drives the master side of kv_flow_table_if, checks init_done/debug.
module tb_kv_flow_table;

    localparam int KS    = 96;
    localparam int IB    = 10;
    localparam int DEPTH = 1 << IB;

    logic       clk156 = 1'b0;
    logic       eth_rst;
    logic       init_done;
    logic [7:0] debug;

    kv_flow_table_if #(.KEY_SIZE(KS)) bus();

    kv_flow_table #(.KEY_SIZE(KS), .IDX_BITS(IB)) dut (
        .clk156   (clk156),
        .eth_rst  (eth_rst),
        .bus      (bus),
        .init_done(init_done),
        .debug    (debug)
    );

    always #5 clk156 = ~clk156;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        longint unsigned due;
        logic [3:0]      flag;
        bit              blk;
        bit              has_lit;
        logic [3:0]      lit;
    } rep_t;

    rep_t            q[$];
    bit              m_valid [DEPTH];
    logic [1:0]      m_stat  [DEPTH];
    logic [KS-1:0]   m_tag   [DEPTH];
    int              init_left = DEPTH;
    int              exp_blk   = 0;
    longint unsigned edge_n    = 0;
    bit              started   = 0;
    bit              drv_has_lit = 0;
    logic [3:0]      drv_lit     = 4'h0;

    function automatic int fold(input logic [KS-1:0] key);
        logic [KS-1:0] k;
        int acc;
        k   = key;
        acc = 0;
        while (k != 0) begin
            acc ^= int'(k[IB-1:0]);
            k = k >> IB;
        end
        return acc;
    endfunction

    // Table model: each request takes effect immediately, in order.
    initial forever begin
        rep_t       r;
        int         idx;
        bit         hit;
        logic [1:0] op;
        @(posedge clk156);
        edge_n++;
        if (eth_rst) begin
            started   = 1;
            init_left = DEPTH;
            exp_blk   = 0;
            q.delete();
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        end else begin
            if (bus.in_valid) begin
                idx = fold(bus.in_key);
                hit = m_valid[idx] && (m_tag[idx] == bus.in_key);
                op  = bus.in_flag[2:1];
                r.due     = edge_n + 1;
                r.flag    = 4'b0000;
                r.blk     = 0;
                r.has_lit = drv_has_lit;
                r.lit     = drv_lit;
                if (init_left == 0) begin
                    if (op == 2'b01) begin
                        if (hit && m_stat[idx] == 2'b10) begin
                            r.flag = 4'b0101;
                            r.blk  = 1;
                        end else if (hit) begin
                            r.flag = 4'b0011;
                        end else begin
                            m_valid[idx] = 1;
                            m_stat[idx]  = 2'b01;
                            m_tag[idx]   = bus.in_key;
                            r.flag       = 4'b0010;
                        end
                    end else if (op == 2'b10) begin
                        if (hit) begin
                            m_stat[idx] = 2'b10;
                            r.flag      = 4'b0111;
                        end
                    end
                end
                q.push_back(r);
            end
            if (init_left > 0) init_left--;
        end
    end

    initial forever begin
        rep_t c;
        @(negedge clk156);
        if (started) begin
            if (q.size() > 0 && q[0].due == edge_n) begin
                c = q.pop_front();
                chk("out_valid", bus.out_valid, 1);
                chk("out_flag", bus.out_flag, c.flag);
                if (c.has_lit) begin
                    chk("model_vs_literal", c.flag, c.lit);
                    chk("out_flag_literal", bus.out_flag, c.lit);
                end
                if (c.blk && exp_blk < 127) exp_blk++;
            end else begin
                chk("out_valid_idle", bus.out_valid, 0);
            end
            chk("init_done", init_done, init_left == 0);
            chk("debug", debug, {init_left == 0, exp_blk[6:0]});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk156);
            bus.in_valid = 1'b0;
            drv_has_lit  = 0;
        end
    endtask

    task automatic send(input logic [KS-1:0] key, input logic [1:0] op,
                        input logic [3:0] lit);
        int r;
        r = $urandom;
        @(negedge clk156);
        bus.in_valid = 1'b1;
        bus.in_key   = key;
        bus.in_flag  = {r[1], op, r[0]};
        drv_has_lit  = 1;
        drv_lit      = lit;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!init_done && n < 2 * DEPTH) begin
            @(negedge clk156);
            bus.in_valid = 1'b0;
            drv_has_lit  = 0;
            n++;
        end
        chk("init_timeout", init_done, 1);
    endtask

    localparam logic [1:0] SUS = 2'b01;
    localparam logic [1:0] ARR = 2'b10;

    logic [KS-1:0] k1, k2, k3, ka, kb;

    initial begin
        k1 = {32'hC0A86401, 32'hC0A86462, 16'd12345, 16'd0};
        k2 = {32'h0A000001, 32'h08080808, 16'd53, 16'd0};
        k3 = {32'hAC100005, 32'h01010101, 16'd4242, 16'd0};
        ka = {32'h11223344, 32'h55667788, 16'd777, 16'd0};
        kb = ka ^ 96'h401;
        eth_rst      = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_key   = '0;
        bus.in_flag  = 4'h0;
        repeat (3) @(negedge clk156);
        eth_rst = 1'b0;

        idle(499);
        send(k1, SUS, 4'b0000);
        idle(522);
        send(k1, SUS, 4'b0000);
        send(k1, SUS, 4'b0010);
        idle(3);
        wait_init();

        send(k1, ARR, 4'b0111);
        idle(2);
        send(k1, SUS, 4'b0101);
        idle(3);
        chk("debug_after_block", debug, 8'h81);

        send(k2, ARR, 4'b0000);
        idle(1);
        send(k2, SUS, 4'b0010);
        idle(2);

        send(k3, SUS, 4'b0010);
        send(k3, ARR, 4'b0111);
        send(k3, SUS, 4'b0101);
        idle(3);
        chk("debug_after_hazard", debug, 8'h82);

        send(k3, 2'b00, 4'b0000);
        send(k2, 2'b11, 4'b0000);
        send(k2, SUS, 4'b0011);
        idle(2);

        send(ka, SUS, 4'b0010);
        send(kb, SUS, 4'b0010);
        idle(1);
        send(ka, ARR, 4'b0000);
        send(kb, SUS, 4'b0011);
        idle(2);

        for (int i = 0; i < 130; i++) send(k3, SUS, 4'b0101);
        idle(3);
        chk("debug_saturated", debug, 8'hFF);

        send(k3, SUS, 4'b0101);
        @(negedge clk156);
        bus.in_valid = 1'b0;
        drv_has_lit  = 0;
        eth_rst      = 1'b1;
        idle(2);
        eth_rst = 1'b0;
        wait_init();
        send(k3, SUS, 4'b0010);
        idle(3);
        chk("debug_after_reset", debug, 8'h80);

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
